// File: rtl/trigger_qualifier_pkg.sv
// -----------------------------------------------------------------------------
// trigger_qualifier_pkg
// Shared types and constants for the trigger qualifier: the controller state
// encoding, the edge-select codes carried on edge_sel, and the width of the
// match-count / edge-counter datapath.
// -----------------------------------------------------------------------------
package trigger_qualifier_pkg;

  localparam int MATCH_W = 16;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FIRE,
    ST_WAIT_DONE
  } state_t;

endpackage

// File: rtl/sync_filter.sv
// -----------------------------------------------------------------------------
// sync_filter
// Brings an asynchronous level into the clk domain through a SYNC_STAGES-deep
// flop chain, then debounces it: the filtered level only follows the
// synchronized value once the two have disagreed for FILTER_CYCLES
// consecutive cycles. Any cycle of agreement restarts the count.
//
// Ports
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset (chain, counter and level -> 0)
//   din    in  asynchronous input level
//   level  out filtered, synchronized level
// -----------------------------------------------------------------------------
module sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level
);

  // Counter only has to reach FILTER_CYCLES-1; keep at least one bit so a
  // filter of 1 still elaborates.
  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       stable_cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: flops are written with non-blocking assignments so every register
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the synchronizer chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      stable_cnt <= '0;
      level      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (synced == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level      <= synced;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/trigger_qualifier.sv
// -----------------------------------------------------------------------------
// trigger_qualifier
// Arms on request, counts debounced edges of the selected polarity on
// target_in, and raises a registered trigger to the glitch generator when the
// requested edge ordinal is reached. The trigger is held until the generator
// completes its done handshake (done low = accepted, then done high = finished).
//
// Optional watchdog: define TRIG_QUAL_TIMEOUT_EN to abort a shot that spends
// TIMEOUT_CYCLES in FIRE/WAIT_DONE, dropping trigger and setting the sticky
// timeout_err flag (cleared by reset or the next accepted arm). Without the
// macro, timeout_err is tied low and the handshake is awaited indefinitely.
//
// Ports
//   clk          in  12 MHz system clock, rising edge
//   rst_n        in  asynchronous active-low reset
//   target_in    in  asynchronous target event line
//   arm          in  single-cycle arm request (honoured only in IDLE)
//   edge_sel     in  0 = rising, 1 = falling; sampled with arm
//   match_count  in  ordinal of the firing edge (0 treated as 1); sampled with arm
//   glitch_done  in  asynchronous done level from the glitch generator
//   trigger      out registered level trigger
//   armed        out high while waiting for qualifying edges
//   timeout_err  out sticky watchdog flag
// -----------------------------------------------------------------------------
module trigger_qualifier
  import trigger_qualifier_pkg::*;
#(
  parameter int          SYNC_STAGES    = 2,
  parameter int          FILTER_CYCLES  = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               target_in,
  input  logic               arm,
  input  logic               edge_sel,
  input  logic [MATCH_W-1:0] match_count,
  input  logic               glitch_done,
  output logic               trigger,
  output logic               armed,
  output logic               timeout_err
);

  logic target_lvl, target_lvl_d, done_lvl;
  logic rise_q, fall_q, qual_edge;

  state_t             state, state_nx;
  logic               sel_q, sel_nx;
  logic [MATCH_W-1:0] match_q, match_nx;
  logic [MATCH_W-1:0] edge_cnt, edge_cnt_nx, edge_inc;
  logic               wd_hit;
  logic               arm_accept;

  sync_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_target_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (target_in),
    .level(target_lvl)
  );

  sync_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(1)
  ) u_done_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (glitch_done),
    .level(done_lvl)
  );

  // Edge pulses are registered once more so the FSM sees an edge exactly
  // SYNC_STAGES+FILTER_CYCLES cycles after the input change, giving the
  // documented trigger latency with a registered trigger.
  assign qual_edge  = (sel_q == EDGE_FALL) ? fall_q : rise_q;
  assign edge_inc   = edge_cnt + MATCH_W'(1);
  assign arm_accept = (state == ST_IDLE) && arm;

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    sel_nx      = sel_q;
    match_nx    = match_q;
    edge_cnt_nx = edge_cnt;
    case (state)
      ST_IDLE: begin
        if (arm) begin
          sel_nx      = edge_sel;
          match_nx    = (match_count == '0) ? MATCH_W'(1) : match_count;
          edge_cnt_nx = '0;
          state_nx    = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (qual_edge) begin
          edge_cnt_nx = edge_inc;
          if (edge_inc == match_q) state_nx = ST_FIRE;
        end
      end
      // Done is still high from the previous shot; wait for it to fall
      // (request accepted) before looking for its rise (shot finished).
      ST_FIRE:      if (!done_lvl) state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done_lvl)  state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
    if (wd_hit) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sel_q        <= EDGE_RISE;
      match_q      <= '0;
      edge_cnt     <= '0;
      trigger      <= 1'b0;
      armed        <= 1'b0;
      target_lvl_d <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      sel_q        <= sel_nx;
      match_q      <= match_nx;
      edge_cnt     <= edge_cnt_nx;
      trigger      <= (state_nx == ST_FIRE) || (state_nx == ST_WAIT_DONE);
      armed        <= (state_nx == ST_ARMED);
      target_lvl_d <= target_lvl;
      rise_q       <= target_lvl & ~target_lvl_d;
      fall_q       <= ~target_lvl & target_lvl_d;
    end
  end

`ifdef TRIG_QUAL_TIMEOUT_EN
  logic [23:0] wd_cnt;
  logic        in_shot;

  assign in_shot = (state == ST_FIRE) || (state == ST_WAIT_DONE);
  assign wd_hit  = in_shot && (wd_cnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt <= in_shot ? wd_cnt + 24'd1 : 24'd0;
      if (wd_hit)          timeout_err <= 1'b1;
      else if (arm_accept) timeout_err <= 1'b0;
    end
  end
`else
  logic unused_timeout;

  assign wd_hit         = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_timeout = ^{TIMEOUT_CYCLES, arm_accept};
`endif

endmodule

// File: doc/trigger_qualifier.md
TRIGGER_QUALIFIER -- requirements
Module: trigger_qualifier

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flops in each input synchronizer (legal 2..4).
REQ-002 SHALL have parameter FILTER_CYCLES, default 4, meaning consecutive stable cycles required before the filtered target level changes (legal 1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 24'd12_000_000, meaning the watchdog limit in clk cycles (used only under REQ-027).
REQ-004 SHALL have port clk, input, 1 bit: the 12 MHz system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port target_in, input, 1 bit: asynchronous target event line.
REQ-007 SHALL have port arm, input, 1 bit: single-cycle arm request.
REQ-008 SHALL have port edge_sel, input, 1 bit: 0 selects rising edges, 1 selects falling edges; sampled with arm.
REQ-009 SHALL have port match_count, input, 16 bits: ordinal of the qualifying edge that fires; sampled with arm.
REQ-010 SHALL have port glitch_done, input, 1 bit: asynchronous done level from the downstream glitch generator.
REQ-011 SHALL have port trigger, output, 1 bit: level trigger to the glitch generator.
REQ-012 SHALL have port armed, output, 1 bit: high while in ARMED.
REQ-013 SHALL have port timeout_err, output, 1 bit: sticky watchdog flag (constant 0 when REQ-028 applies).

Function
REQ-014 SHALL synchronize target_in and glitch_done through SYNC_STAGES flops each.
REQ-015 SHALL change the filtered target level only when the synchronized value has differed from it for FILTER_CYCLES consecutive cycles; any return to the filtered value restarts the count.
REQ-016 SHALL detect a qualifying edge as a filtered-level transition matching the latched edge_sel.
REQ-017 SHALL implement states IDLE, ARMED, FIRE, WAIT_DONE.
REQ-018 SHALL, in IDLE, on arm=1, latch edge_sel and match_count, clear the edge counter, and enter ARMED next cycle; a latched match_count of 0 is treated as 1.
REQ-019 SHALL ignore arm in any state other than IDLE.
REQ-020 SHALL not count an edge detected in the same cycle that arm is accepted.
REQ-021 SHALL, in ARMED, increment a 16-bit edge counter per qualifying edge and enter FIRE in the cycle the count reaches the latched match_count.
REQ-022 SHALL assert trigger from the first cycle of FIRE until WAIT_DONE exits; trigger is registered, with no combinational path from inputs.
REQ-023 SHALL, in FIRE, advance to WAIT_DONE on the first cycle synchronized glitch_done=0 (downstream accepted); it SHALL remain in FIRE while glitch_done=1, because done stays high from the previous shot.
REQ-024 SHALL, in WAIT_DONE, deassert trigger and return to IDLE on the first cycle synchronized glitch_done=1.
REQ-025 SHALL raise trigger exactly SYNC_STAGES+FILTER_CYCLES+1 clk cycles after the clk edge that first samples the qualifying target_in transition, when match_count=1.

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-shot, force state IDLE, trigger=0, armed=0, timeout_err=0, edge counter=0, filtered level=0, and all synchronizer flops=0; it SHALL release synchronously to clk.

Configuration
REQ-027 SHALL, with TRIG_QUAL_TIMEOUT_EN defined, count cycles spent in FIRE+WAIT_DONE; when the count reaches TIMEOUT_CYCLES, it SHALL drop trigger, enter IDLE, and set timeout_err, which clears only on reset or the next accepted arm.
REQ-028 SHALL, without TRIG_QUAL_TIMEOUT_EN, omit the watchdog counter, tie timeout_err to 0, and wait in FIRE/WAIT_DONE indefinitely.

Structure
REQ-029 SHALL place the state enum, the EDGE_RISE/EDGE_FALL constants, and the match-count width in package trigger_qualifier_pkg.
REQ-030 SHALL implement synchronizer+filter as sub-module sync_filter, instantiated for target_in (FILTER_CYCLES) and glitch_done (filter of 1).

Verification
REQ-031 SHALL cover: edge_sel=0, match_count=1, arm, then clean rising target -> trigger high 7 cycles later (defaults); done 0 then 1 -> trigger low, IDLE.
REQ-032 SHALL cover: target pulses of 3 cycles -> no filtered edge, trigger stays 0; a 4-cycle pulse -> exactly one count.
REQ-033 SHALL cover: edge_sel=1, match_count=3, five falling edges -> trigger on the 3rd edge only; match_count=0 -> fires on the 1st edge.
REQ-034 SHALL cover: arm coincident with a filtered edge -> that edge not counted; arm during ARMED/FIRE -> ignored, latched values unchanged.
REQ-035 SHALL cover: rst_n low during WAIT_DONE -> trigger=0, armed=0 immediately (asynchronously), IDLE after release.
REQ-036 SHALL cover: with TRIG_QUAL_TIMEOUT_EN and TIMEOUT_CYCLES=100, glitch_done held 1 -> trigger drops after 100 cycles, timeout_err=1, cleared by next arm.
